mem_port_master: RTL
====================

# mem_port_master

Client-side request port for one device slot of the three-way memory arbiter. It accepts single-word or burst read/write requests from a client (fetch unit, load/store unit, DMA) and drives the slot's `mem_en`/`mem_addr`/`mem_di`/`bank_select`/`mem_we`/`burst_en` lines. It holds each request stable until the arbiter acknowledges it, then returns read data to the client one word per acknowledge.

## Interface
- `DATA_DELAY`, default 1: cycles from an acknowledged edge to the edge on which `mem_do` holds that word's data. Legal range 0..3.
- `clk` input 1: clock; all state on the rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `req_valid` input 1: client request present.
- `req_ready` output 1: port idle and able to accept a request.
- `req_we` input 1: 1 = write, 0 = read.
- `req_addr` input 16: byte address of the first word; bits [1:0] are ignored and forced to 0.
- `req_wdata` input 32: write data (single word).
- `req_bank_select` input 4: byte-lane enables.
- `req_len` input 4: burst length minus 1 (0 = one word). Forced to 0 for writes.
- `rsp_valid` output 1: one-cycle pulse per completed word.
- `rsp_data` output 32: read word (0 for writes).
- `rsp_last` output 1: final word of the request; qualified by `rsp_valid`.
- `mem_en` output 1: request to the arbiter slot.
- `mem_addr` output 16: word address presented to the arbiter.
- `mem_di` output 32: write data to the arbiter.
- `bank_select` output 4: byte lanes to the arbiter.
- `mem_we` output 1: write strobe to the arbiter.
- `burst_en` output 1: burst hint to the arbiter.
- `do_ack` input 1: this slot's acknowledge bit from the arbiter.
- `mem_do` input 32: shared memory read data.

## Operation
- FSM states are IDLE, REQ and DRAIN. All outputs are registered.
- In IDLE, `req_ready` is 1. When `req_valid` and `req_ready` are both high on an edge, the port latches addr, wdata, bank, we and len, sets `remaining` to len, and moves to REQ.
- In REQ, `mem_en` is 1 and the attributes are held stable. On each edge where `do_ack` is 1:
  - `mem_addr` advances by 4, modulo 2^16 (0xFFFC wraps to 0x0000).
  - If `remaining` is 0, the port drops `mem_en` and goes to DRAIN, or straight to IDLE when DATA_DELAY is 0.
  - Otherwise `remaining` decrements.
- Each acknowledge pushes a tag into a DATA_DELAY-deep shift pipeline. The tag is {valid, last, we}.
- When a tag emerges from the pipeline, the port registers `rsp_data` from `mem_do` (0 if we), and asserts `rsp_valid` and `rsp_last` on the next cycle.
- DRAIN waits until the pipeline is empty, then goes to IDLE.
- A `do_ack` in IDLE or DRAIN is ignored: no pipeline push and no response.
- `req_valid` outside IDLE is ignored. The client holds the request until `req_ready`.
- Reset values: `req_ready` 1; `rsp_valid`, `rsp_last`, `mem_en`, `mem_we`, `burst_en` all 0; `rsp_data`, `mem_addr`, `mem_di` all 0; `bank_select` 4'b0000; state IDLE; pipeline cleared.
- Reset mid-request clears everything immediately. No response is issued for the aborted request.

## Timing
- Request accepted at edge t: `mem_en` is high from cycle t+1.
- Acknowledge sampled at edge k: `rsp_valid` is high in cycle k+DATA_DELAY+1.
- Throughput is one word per acknowledged cycle. Back-to-back acknowledges are legal.
- Minimum idle gap between requests: `req_ready` returns the cycle after the last acknowledge (DATA_DELAY 0) or after the drain completes.
- `rsp_valid` for the last word may coincide with `req_ready`. Responses are in order.

## Configuration
- `MEM_PORT_BURST_EN` defined:
  - `burst_en` is 1 in REQ while `remaining` is not 0.
  - `mem_en` stays high across the whole burst.
- Not defined:
  - `burst_en` is tied to 0.
  - After each non-final acknowledge, `mem_en` drops for exactly one cycle before re-asserting with the next address. This lets the arbiter rotate fairly.
  - Response ordering and count are unchanged.

## Structure
- Shared package `mem_pkg`: state encoding (IDLE/REQ/DRAIN), `MEM_ADDR_W` = 16, `MEM_DATA_W` = 32, `MEM_BANK_W` = 4, `WORD_STRIDE` = 4.
- One sub-module, `ack_delay_line`: a parameterised DATA_DELAY-deep tag shift register with an empty flag. DATA_DELAY 0 is a pass-through.

## Test plan
- Single read: addr 0x0010, ack one cycle after `mem_en`, `mem_do` = 0xDEADBEEF at DATA_DELAY 1. Expect one `rsp_valid` with data 0xDEADBEEF, `rsp_last` = 1, and `mem_en` low the cycle after the ack.
- Burst read: len 3, addr 0x0100, continuous acks. Expect `mem_addr` 0x100, 0x104, 0x108, 0x10C, four in-order responses, and `rsp_last` only on the 4th. Without the macro, expect a one-cycle `mem_en` gap between words.
- Wrap: burst len 1 at 0xFFFC. Expect the second address to be 0x0000.
- Write: we = 1, wdata 0x12345678, bank 4'b0011, len 7. Expect exactly one ack consumed, `mem_di`/`bank_select` held until the ack, and one response with data 0 and `rsp_last` = 1.
- Stalled ack plus spurious ack: hold `do_ack` low for 10 cycles, and pulse `do_ack` while in IDLE. Expect the attributes stable throughout and no response for the spurious ack.
- Reset mid-burst after 2 of 4 acks: expect all outputs at their reset values immediately, no further `rsp_valid`, and `req_ready` = 1.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory arbiter client ports: bus widths, FSM
// state encoding and the acknowledge tag carried through the data-delay pipeline.
package mem_pkg;

   localparam int MEM_ADDR_W  = 16;
   localparam int MEM_DATA_W  = 32;
   localparam int MEM_BANK_W  = 4;
   localparam int WORD_STRIDE = 4;
   localparam int MEM_LEN_W   = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      DRAIN = 2'd2
   } port_state_e;

   typedef struct packed {
      logic valid;
      logic last;
      logic we;
   } ack_tag_t;

endpackage

// File: rtl/ack_delay_line.sv
// DEPTH-stage shift register of acknowledge tags with an empty flag; DEPTH 0
// passes the tag straight through and always reports empty.
module ack_delay_line
   import mem_pkg::*;
#(
   parameter int DEPTH = 1
) (
   input  logic     clk,
   input  logic     reset,
   input  ack_tag_t tag_in,
   output ack_tag_t tag_out,
   output logic     empty
);

   generate
      if (DEPTH == 0) begin : g_bypass
         assign tag_out = tag_in;
         assign empty   = 1'b1;
      end else begin : g_pipe
         ack_tag_t stage [DEPTH];

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               for (int i = 0; i < DEPTH; i++) begin
                  stage[i] <= '0;
               end
            end else begin
               stage[0] <= tag_in;
               for (int i = 1; i < DEPTH; i++) begin
                  stage[i] <= stage[i-1];
               end
            end
         end

         assign tag_out = stage[DEPTH-1];

         always_comb begin
            empty = 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
               if (stage[i].valid) begin
                  empty = 1'b0;
               end
            end
         end
      end
   endgenerate

endmodule

// File: rtl/mem_port_master.sv
// Client request port for one arbiter slot: holds a request until acknowledged and
// returns data in order. Define MEM_PORT_BURST_EN to keep mem_en high across bursts.
module mem_port_master
   import mem_pkg::*;
#(
   parameter int DATA_DELAY = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [MEM_ADDR_W-1:0] req_addr,
   input  logic [MEM_DATA_W-1:0] req_wdata,
   input  logic [MEM_BANK_W-1:0] req_bank_select,
   input  logic [MEM_LEN_W-1:0]  req_len,
   output logic                  rsp_valid,
   output logic [MEM_DATA_W-1:0] rsp_data,
   output logic                  rsp_last,
   output logic                  mem_en,
   output logic [MEM_ADDR_W-1:0] mem_addr,
   output logic [MEM_DATA_W-1:0] mem_di,
   output logic [MEM_BANK_W-1:0] bank_select,
   output logic                  mem_we,
   output logic                  burst_en,
   input  logic                  do_ack,
   input  logic [MEM_DATA_W-1:0] mem_do
);

   port_state_e           state, state_n;
   logic [MEM_LEN_W-1:0]  remaining, remaining_n;
   logic                  is_write, is_write_n;
   logic                  req_ready_n, mem_en_n, mem_we_n, burst_en_n;
   logic [MEM_ADDR_W-1:0] mem_addr_n;
   logic [MEM_DATA_W-1:0] mem_di_n, rsp_data_n;
   logic [MEM_BANK_W-1:0] bank_select_n;
   logic                  rsp_valid_n, rsp_last_n;
   logic                  ack_take;
   ack_tag_t              tag_in, tag_out;
   logic                  pipe_empty;

   // Acks only count while the request is actually presented (not in the rotation gap).
   assign ack_take = (state == REQ) && mem_en && do_ack;
   assign tag_in   = {ack_take, (remaining == '0), is_write};

   ack_delay_line #(
      .DEPTH(DATA_DELAY)
   ) u_ack_delay (
      .clk    (clk),
      .reset  (reset),
      .tag_in (tag_in),
      .tag_out(tag_out),
      .empty  (pipe_empty)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         remaining   <= '0;
         is_write    <= 1'b0;
         req_ready   <= 1'b1;
         mem_en      <= 1'b0;
         mem_we      <= 1'b0;
         burst_en    <= 1'b0;
         mem_addr    <= '0;
         mem_di      <= '0;
         bank_select <= '0;
         rsp_valid   <= 1'b0;
         rsp_last    <= 1'b0;
         rsp_data    <= '0;
      end else begin
         state       <= state_n;
         remaining   <= remaining_n;
         is_write    <= is_write_n;
         req_ready   <= req_ready_n;
         mem_en      <= mem_en_n;
         mem_we      <= mem_we_n;
         burst_en    <= burst_en_n;
         mem_addr    <= mem_addr_n;
         mem_di      <= mem_di_n;
         bank_select <= bank_select_n;
         rsp_valid   <= rsp_valid_n;
         rsp_last    <= rsp_last_n;
         rsp_data    <= rsp_data_n;
      end
   end

   always_comb begin
      state_n       = state;
      remaining_n   = remaining;
      is_write_n    = is_write;
      mem_en_n      = mem_en;
      mem_addr_n    = mem_addr;
      mem_di_n      = mem_di;
      bank_select_n = bank_select;
      rsp_valid_n   = tag_out.valid;
      rsp_last_n    = tag_out.valid & tag_out.last;
      rsp_data_n    = rsp_data;
      if (tag_out.valid) begin
         rsp_data_n = tag_out.we ? '0 : mem_do;
      end

      case (state)
         IDLE: begin
            if (req_valid) begin
               state_n       = REQ;
               mem_addr_n    = req_addr & ~16'h0003;
               mem_di_n      = req_wdata;
               bank_select_n = req_bank_select;
               is_write_n    = req_we;
               remaining_n   = req_we ? '0 : req_len;
               mem_en_n      = 1'b1;
            end
         end
         REQ: begin
            if (ack_take) begin
               mem_addr_n = mem_addr + MEM_ADDR_W'(WORD_STRIDE);
               if (remaining == '0) begin
                  mem_en_n = 1'b0;
                  state_n  = (DATA_DELAY == 0) ? IDLE : DRAIN;
               end else begin
                  remaining_n = remaining - 1'b1;
`ifdef MEM_PORT_BURST_EN
                  mem_en_n = 1'b1;
`else
                  mem_en_n = 1'b0;
`endif
               end
            end else if (!mem_en) begin
               mem_en_n = 1'b1;
            end
         end
         DRAIN: begin
            if (pipe_empty) begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase

      req_ready_n = (state_n == IDLE);
      mem_we_n    = mem_en_n & is_write_n;
`ifdef MEM_PORT_BURST_EN
      burst_en_n  = (state_n == REQ) && (remaining_n != '0);
`else
      burst_en_n  = 1'b0;
`endif
   end

endmodule
